// File: rtl/operand_router_pipe.sv
// Operand router for the Kalman ALU: selects R/S/I from bank ports, temp registers
// or constants, with optional inversion, behind a single valid/ready output register.
module operand_router_pipe #(
  parameter int W    = 24,
  parameter int NSRC = 4,
  parameter int FWD  = 1,
  localparam int SW  = $clog2(NSRC + 4)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSRC*W-1:0] bank_data,
  input  logic [W-1:0]      alu_result,
  input  logic              ld_RQ,
  input  logic              ld_RD,
  input  logic [W-1:0]      imm_wdata,
  input  logic              ld_imm,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SW-1:0]     sel_R,
  input  logic [SW-1:0]     sel_S,
  input  logic              inv_R,
  input  logic              inv_S,
  input  logic [1:0]        sel_I,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      R,
  output logic [W-1:0]      S,
  output logic [W-1:0]      I,
  output logic              msb_R,
  output logic              msb_S,
  output logic [W-1:0]      RQ,
  output logic [W-1:0]      RD
);

  logic [W-1:0] bank_port [NSRC];
  logic [W-1:0] rq_reg, rd_reg, imm_reg;
  logic [W-1:0] r_reg, s_reg, i_reg;
  logic         out_valid_reg;
  logic [W-1:0] rq_src, rd_src, imm_src;
  logic [W-1:0] r_sel, s_sel;
  logic [W-1:0] r_next, s_next, i_next;
  logic         accept;

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_port
      assign bank_port[gi] = bank_data[gi*W +: W];
    end
  endgenerate

  // Same-edge writebacks bypass the temp registers when forwarding is enabled.
  assign rq_src  = ((FWD != 0) && ld_RQ)  ? alu_result : rq_reg;
  assign rd_src  = ((FWD != 0) && ld_RD)  ? alu_result : rd_reg;
  assign imm_src = ((FWD != 0) && ld_imm) ? imm_wdata  : imm_reg;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  // Codes beyond NSRC+2 fall through to all-ones, so every code is defined.
  always_comb begin
    r_sel = '1;
    s_sel = '1;
    for (int k = 0; k < NSRC; k++) begin
      if (sel_R == SW'(k)) r_sel = bank_port[k];
      if (sel_S == SW'(k)) s_sel = bank_port[k];
    end
    if (sel_R == SW'(NSRC))     r_sel = rq_src;
    if (sel_R == SW'(NSRC + 1)) r_sel = rd_src;
    if (sel_R == SW'(NSRC + 2)) r_sel = '0;
    if (sel_S == SW'(NSRC))     s_sel = rq_src;
    if (sel_S == SW'(NSRC + 1)) s_sel = rd_src;
    if (sel_S == SW'(NSRC + 2)) s_sel = '0;
  end

  always_comb begin
    r_next = inv_R ? ~r_sel : r_sel;
    s_next = inv_S ? ~s_sel : s_sel;
    case (sel_I)
      2'b00:   i_next = '0;
      2'b01:   i_next = W'(1);
      2'b10:   i_next = '1;
      default: i_next = imm_src;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq_reg  <= '0;
      rd_reg  <= '0;
      imm_reg <= '0;
    end else begin
      if (ld_RQ)  rq_reg  <= alu_result;
      if (ld_RD)  rd_reg  <= alu_result;
      if (ld_imm) imm_reg <= imm_wdata;
    end
  end

  // Data outputs only move on accept; a drained register keeps its last operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      r_reg         <= '0;
      s_reg         <= '0;
      i_reg         <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      r_reg         <= r_next;
      s_reg         <= s_next;
      i_reg         <= i_next;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign R         = r_reg;
  assign S         = s_reg;
  assign I         = i_reg;
  assign msb_R     = r_reg[W-1];
  assign msb_S     = s_reg[W-1];
  assign RQ        = rq_reg;
  assign RD        = rd_reg;

endmodule

// File: tb/tb_operand_router_pipe.sv
// Bench for operand_router_pipe: table-driven issues checked through a scoreboard
// queue, plus hand-written forwarding, backpressure, bubble and reset sequences.
module tb_operand_router_pipe;
  localparam int W = 24;
  localparam int NSRC = 4;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst;
  logic [NSRC*W-1:0] bank_data;
  logic [W-1:0] alu_result, imm_wdata;
  logic ld_RQ, ld_RD, ld_imm, in_valid, out_ready;
  logic [SW-1:0] sel_R, sel_S;
  logic inv_R, inv_S;
  logic [1:0] sel_I;
  logic in_ready, out_valid, msb_R, msb_S;
  logic [W-1:0] R, S, I, RQ, RD;
  logic in_ready_nf, out_valid_nf, msb_R_nf, msb_S_nf;
  logic [W-1:0] R_nf, S_nf, I_nf, RQ_nf, RD_nf;

  always #5 clk = ~clk;

  operand_router_pipe #(.W(W), .NSRC(NSRC), .FWD(1)) dut (
    .clk(clk), .rst(rst), .bank_data(bank_data), .alu_result(alu_result),
    .ld_RQ(ld_RQ), .ld_RD(ld_RD), .imm_wdata(imm_wdata), .ld_imm(ld_imm),
    .in_valid(in_valid), .in_ready(in_ready), .sel_R(sel_R), .sel_S(sel_S),
    .inv_R(inv_R), .inv_S(inv_S), .sel_I(sel_I), .out_valid(out_valid),
    .out_ready(out_ready), .R(R), .S(S), .I(I), .msb_R(msb_R), .msb_S(msb_S),
    .RQ(RQ), .RD(RD));

  operand_router_pipe #(.W(W), .NSRC(NSRC), .FWD(0)) dut_nf (
    .clk(clk), .rst(rst), .bank_data(bank_data), .alu_result(alu_result),
    .ld_RQ(ld_RQ), .ld_RD(ld_RD), .imm_wdata(imm_wdata), .ld_imm(ld_imm),
    .in_valid(in_valid), .in_ready(in_ready_nf), .sel_R(sel_R), .sel_S(sel_S),
    .inv_R(inv_R), .inv_S(inv_S), .sel_I(sel_I), .out_valid(out_valid_nf),
    .out_ready(out_ready), .R(R_nf), .S(S_nf), .I(I_nf), .msb_R(msb_R_nf),
    .msb_S(msb_S_nf), .RQ(RQ_nf), .RD(RD_nf));

  typedef struct {
    logic [SW-1:0] sel_R;
    logic [SW-1:0] sel_S;
    logic          inv_R;
    logic          inv_S;
    logic [1:0]    sel_I;
    logic [W-1:0]  exp_R;
    logic [W-1:0]  exp_S;
    logic [W-1:0]  exp_I;
  } vec_t;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] s;
    logic [W-1:0] i;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int n_issued = 0;
  int n_deliv = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // Drive one request, wait (bounded) for in_ready, record its expected result.
  task automatic issue(input vec_t v);
    int n;
    sel_R = v.sel_R; sel_S = v.sel_S; inv_R = v.inv_R; inv_S = v.inv_S;
    sel_I = v.sel_I; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("issue_timeout", 96'd0, 96'd1);
    end else begin
      exp_q.push_back('{v.exp_R, v.exp_S, v.exp_I});
      n_issued++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard: one comparison per completed output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("out_unexpected", 96'd1, 96'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_deliv++;
        chk("out_RSI_msb", {22'd0, R, S, I, msb_R, msb_S},
            {22'd0, e.r, e.s, e.i, e.r[W-1], e.s[W-1]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

  vec_t tbl[7];
  vec_t bp[3];
  vec_t v;

  initial begin
    tbl[0] = '{3'd2, 3'd6, 1'b0, 1'b0, 2'b01, 24'h123456, 24'h000000, 24'h000001};
    tbl[1] = '{3'd0, 3'd7, 1'b1, 1'b0, 2'b11, 24'hFF0000, 24'hFFFFFF, 24'hABCDEF};
    tbl[2] = '{3'd4, 3'd5, 1'b0, 1'b1, 2'b10, 24'h000010, 24'hF0F0F0, 24'hFFFFFF};
    tbl[3] = '{3'd1, 3'd3, 1'b0, 1'b0, 2'b00, 24'hA5A5A5, 24'h800000, 24'h000000};
    tbl[4] = '{3'd6, 3'd7, 1'b1, 1'b1, 2'b01, 24'hFFFFFF, 24'h000000, 24'h000001};
    tbl[5] = '{3'd5, 3'd4, 1'b0, 1'b1, 2'b11, 24'h0F0F0F, 24'hFFFFEF, 24'hABCDEF};
    tbl[6] = '{3'd3, 3'd2, 1'b1, 1'b1, 2'b10, 24'h7FFFFF, 24'hEDCBA9, 24'hFFFFFF};
    bp[0]  = '{3'd1, 3'd0, 1'b0, 1'b0, 2'b00, 24'hA5A5A5, 24'h00FFFF, 24'h000000};
    bp[1]  = '{3'd2, 3'd3, 1'b0, 1'b0, 2'b01, 24'h123456, 24'h800000, 24'h000001};
    bp[2]  = '{3'd0, 3'd6, 1'b1, 1'b0, 2'b10, 24'hFF0000, 24'h000000, 24'hFFFFFF};

    rst = 1'b1;
    bank_data = {24'h800000, 24'h123456, 24'hA5A5A5, 24'h00FFFF};
    alu_result = '0; imm_wdata = '0;
    ld_RQ = 0; ld_RD = 0; ld_imm = 0; in_valid = 0; out_ready = 1;
    sel_R = '0; sel_S = '0; inv_R = 0; inv_S = 0; sel_I = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {26'd0, out_valid, in_ready, R, S, I},
        {26'd0, 1'b0, 1'b1, 24'd0, 24'd0, 24'd0});
    chk("reset_temps", {48'd0, RQ, RD}, 96'd0);
    rst = 1'b0;

    // All three temp loads on the same edge, then RQ alone.
    @(posedge clk); #1;
    alu_result = 24'h0F0F0F; imm_wdata = 24'hABCDEF;
    ld_RQ = 1; ld_RD = 1; ld_imm = 1;
    @(posedge clk); #1;
    alu_result = 24'h000010; ld_RD = 0; ld_imm = 0;
    @(posedge clk); #1;
    ld_RQ = 0;
    chk("temp_loads", {48'd0, RQ, RD}, {48'd0, 24'h000010, 24'h0F0F0F});

    for (int k = 0; k < 7; k++) issue(tbl[k]);

    // Backpressure: hold the second result for two edges.
    fork
      begin
        for (int k = 0; k < 3; k++) issue(bp[k]);
      end
      begin
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!(out_valid && R == 24'h123456) && n < 40) begin
          @(posedge clk); #1;
          n++;
        end
        if (n >= 40) chk("bp_wait_timeout", 96'd0, 96'd1);
        out_ready = 1'b0;
        repeat (2) begin
          @(negedge clk);
          chk("bp_stall", {24'd0, out_valid, in_ready, R, S, I[21:0]},
              {24'd0, 1'b1, 1'b0, 24'h123456, 24'h800000, 22'h000001});
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join

    // Forwarding on RQ, RD and IMM together against the non-forwarding copy.
    alu_result = 24'h800001; imm_wdata = 24'h135790;
    ld_RQ = 1; ld_RD = 1; ld_imm = 1;
    v = '{3'd4, 3'd5, 1'b0, 1'b0, 2'b11, 24'h800001, 24'h800001, 24'h135790};
    issue(v);
    ld_RQ = 0; ld_RD = 0; ld_imm = 0;
    chk("fwd1_msb", {94'd0, msb_R, msb_S}, {94'd0, 1'b1, 1'b1});
    chk("fwd0_RSI", {24'd0, R_nf, S_nf, I_nf}, {24'd0, 24'h000010, 24'h0F0F0F, 24'hABCDEF});
    chk("fwd_temps", {24'd0, RQ, RD, RQ_nf}, {24'd0, 24'h800001, 24'h800001, 24'h800001});

    // Bubble: consumed with no new request; data stays put.
    @(posedge clk); #1;
    chk("bubble", {23'd0, out_valid, R, S, I}, {23'd0, 1'b0, 24'h800001, 24'h800001, 24'h135790});
    chk("delivered", {64'd0, 32'(n_deliv)}, {64'd0, 32'(n_issued)});
    chk("queue_empty", 96'(exp_q.size()), 96'd0);

    // Reset while stalled acts immediately.
    out_ready = 1'b0;
    v = '{3'd1, 3'd1, 1'b0, 1'b0, 2'b10, 24'hA5A5A5, 24'hA5A5A5, 24'hFFFFFF};
    issue(v);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst_async", {23'd0, out_valid, R, S, I}, 96'd0);
    chk("rst_async_temps", {48'd0, RQ, RD}, 96'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // IMM cleared by reset.
    v = '{3'd6, 3'd7, 1'b0, 1'b0, 2'b11, 24'h000000, 24'hFFFFFF, 24'h000000};
    issue(v);
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(negedge clk);
    chk("final_drain", 96'(exp_q.size()), 96'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
